// File: rtl/cmac_pe_row.sv
// cmac_pe_row: linear row of NUM_PE complex multiply-accumulate stages sharing one weight
// stream. The weight and the valid/last tags hop one stage per cycle. Lane i data is delayed
// by i registers, so callers present all lanes aligned. Each stage sums a multi-term dot
// product closed by in_last and emits a one-cycle out_valid pulse with the result.
// Optional feature: define CMAC_PE_ROW_SAT_EN to clip results to signed OUT_LEN bits and
// report clipping on sat_flag.
module cmac_pe_row #(
    parameter int unsigned WORD_LEN = 24,
    parameter int unsigned NUM_PE   = 4,
    parameter int unsigned ACC_LEN  = 64,
    parameter int unsigned OUT_LEN  = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clr,
    input  logic                        in_valid,
    input  logic                        in_last,
    input  logic [NUM_PE*WORD_LEN-1:0]  din_R,
    input  logic [NUM_PE*WORD_LEN-1:0]  din_I,
    input  logic [WORD_LEN-1:0]         w_R,
    input  logic [WORD_LEN-1:0]         w_I,
    output logic [NUM_PE*ACC_LEN-1:0]   dout_R,
    output logic [NUM_PE*ACC_LEN-1:0]   dout_I,
    output logic [NUM_PE-1:0]           out_valid,
    output logic [NUM_PE-1:0]           sat_flag,
    output logic                        busy
);

    localparam int unsigned MulLen  = 2 * WORD_LEN;
    localparam int unsigned ProdLen = 2 * WORD_LEN + 1;

`ifdef CMAC_PE_ROW_SAT_EN
    localparam logic signed [ACC_LEN-1:0] SatMax =
        {{(ACC_LEN - OUT_LEN + 1){1'b0}}, {(OUT_LEN - 1){1'b1}}};
    localparam logic signed [ACC_LEN-1:0] SatMin =
        {{(ACC_LEN - OUT_LEN + 1){1'b1}}, {(OUT_LEN - 1){1'b0}}};
`endif

    if (NUM_PE < 1 || ACC_LEN < ProdLen || OUT_LEN < 2 || OUT_LEN > ACC_LEN) begin : g_bad_cfg
        $error("cmac_pe_row: invalid parameter combination");
    end

    // Operands and tags as seen by each stage on the edge it processes them.
    logic [NUM_PE-1:0]          st_v;
    logic [NUM_PE-1:0]          st_l;
    logic [NUM_PE-1:0]          chain_v;
    logic [NUM_PE-1:0]          part_vec;
    logic signed [WORD_LEN-1:0] st_w_re [NUM_PE];
    logic signed [WORD_LEN-1:0] st_w_im [NUM_PE];
    logic signed [WORD_LEN-1:0] st_d_re [NUM_PE];
    logic signed [WORD_LEN-1:0] st_d_im [NUM_PE];

    for (genvar i = 0; i < NUM_PE; i++) begin : g_stage
        if (i == 0) begin : g_head
            // Stage 0 works straight off the aligned inputs.
            assign st_v[0]    = in_valid;
            assign st_l[0]    = in_last;
            assign st_w_re[0] = w_R;
            assign st_w_im[0] = w_I;
            assign st_d_re[0] = din_R[0 +: WORD_LEN];
            assign st_d_im[0] = din_I[0 +: WORD_LEN];
            assign chain_v[0] = 1'b0;
        end else begin : g_hop
            logic                       v_q;
            logic                       l_q;
            logic signed [WORD_LEN-1:0] w_re_q;
            logic signed [WORD_LEN-1:0] w_im_q;
            logic signed [WORD_LEN-1:0] d_re_q [i];
            logic signed [WORD_LEN-1:0] d_im_q [i];

            // Advance tags/weight one hop and lane i data one tap; bubbles and clr load zeros.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_q    <= 1'b0;
                    l_q    <= 1'b0;
                    w_re_q <= '0;
                    w_im_q <= '0;
                    for (int j = 0; j < i; j++) begin
                        d_re_q[j] <= '0;
                        d_im_q[j] <= '0;
                    end
                end else if (clr) begin
                    v_q    <= 1'b0;
                    l_q    <= 1'b0;
                    w_re_q <= '0;
                    w_im_q <= '0;
                    for (int j = 0; j < i; j++) begin
                        d_re_q[j] <= '0;
                        d_im_q[j] <= '0;
                    end
                end else begin
                    v_q       <= st_v[i-1];
                    l_q       <= st_v[i-1] & st_l[i-1];
                    w_re_q    <= st_v[i-1] ? st_w_re[i-1] : '0;
                    w_im_q    <= st_v[i-1] ? st_w_im[i-1] : '0;
                    d_re_q[0] <= in_valid ? $signed(din_R[i*WORD_LEN +: WORD_LEN]) : '0;
                    d_im_q[0] <= in_valid ? $signed(din_I[i*WORD_LEN +: WORD_LEN]) : '0;
                    for (int j = 1; j < i; j++) begin
                        d_re_q[j] <= d_re_q[j-1];
                        d_im_q[j] <= d_im_q[j-1];
                    end
                end
            end

            assign st_v[i]    = v_q;
            assign st_l[i]    = l_q;
            assign st_w_re[i] = w_re_q;
            assign st_w_im[i] = w_im_q;
            assign st_d_re[i] = d_re_q[i-1];
            assign st_d_im[i] = d_im_q[i-1];
            assign chain_v[i] = v_q;
        end

        logic signed [MulLen-1:0]  prod_rr;
        logic signed [MulLen-1:0]  prod_ii;
        logic signed [MulLen-1:0]  prod_ri;
        logic signed [MulLen-1:0]  prod_ir;
        logic signed [ProdLen-1:0] p_re;
        logic signed [ProdLen-1:0] p_im;
        logic signed [ACC_LEN-1:0] sum_re;
        logic signed [ACC_LEN-1:0] sum_im;
        logic signed [ACC_LEN-1:0] res_re;
        logic signed [ACC_LEN-1:0] res_im;
        logic signed [ACC_LEN-1:0] acc_re_q;
        logic signed [ACC_LEN-1:0] acc_im_q;
        logic signed [ACC_LEN-1:0] dout_re_q;
        logic signed [ACC_LEN-1:0] dout_im_q;
        logic                      ov_q;
        logic                      part_q;
`ifdef CMAC_PE_ROW_SAT_EN
        logic                      clip;
        logic                      sf_q;
`endif

        // Full-precision complex product, running sum and (optionally clipped) result value.
        always_comb begin
            prod_rr = MulLen'(st_d_re[i]) * MulLen'(st_w_re[i]);
            prod_ii = MulLen'(st_d_im[i]) * MulLen'(st_w_im[i]);
            prod_ri = MulLen'(st_d_re[i]) * MulLen'(st_w_im[i]);
            prod_ir = MulLen'(st_d_im[i]) * MulLen'(st_w_re[i]);
            p_re    = ProdLen'(prod_rr) - ProdLen'(prod_ii);
            p_im    = ProdLen'(prod_ri) + ProdLen'(prod_ir);
            sum_re  = acc_re_q + ACC_LEN'(p_re);
            sum_im  = acc_im_q + ACC_LEN'(p_im);
            res_re  = sum_re;
            res_im  = sum_im;
`ifdef CMAC_PE_ROW_SAT_EN
            clip = 1'b0;
            if (sum_re > SatMax) begin
                res_re = SatMax;
                clip   = 1'b1;
            end else if (sum_re < SatMin) begin
                res_re = SatMin;
                clip   = 1'b1;
            end
            if (sum_im > SatMax) begin
                res_im = SatMax;
                clip   = 1'b1;
            end else if (sum_im < SatMin) begin
                res_im = SatMin;
                clip   = 1'b1;
            end
`endif
        end

        // Accumulate valid terms; on the last term publish the result and restart from zero.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                acc_re_q  <= '0;
                acc_im_q  <= '0;
                dout_re_q <= '0;
                dout_im_q <= '0;
                ov_q      <= 1'b0;
                part_q    <= 1'b0;
`ifdef CMAC_PE_ROW_SAT_EN
                sf_q      <= 1'b0;
`endif
            end else if (clr) begin
                // dout deliberately survives a flush.
                acc_re_q  <= '0;
                acc_im_q  <= '0;
                ov_q      <= 1'b0;
                part_q    <= 1'b0;
`ifdef CMAC_PE_ROW_SAT_EN
                sf_q      <= 1'b0;
`endif
            end else begin
                ov_q <= st_v[i] & st_l[i];
`ifdef CMAC_PE_ROW_SAT_EN
                sf_q <= st_v[i] & st_l[i] & clip;
`endif
                if (st_v[i]) begin
                    if (st_l[i]) begin
                        dout_re_q <= res_re;
                        dout_im_q <= res_im;
                        acc_re_q  <= '0;
                        acc_im_q  <= '0;
                        part_q    <= 1'b0;
                    end else begin
                        acc_re_q  <= sum_re;
                        acc_im_q  <= sum_im;
                        part_q    <= 1'b1;
                    end
                end
            end
        end

        assign dout_R[i*ACC_LEN +: ACC_LEN] = dout_re_q;
        assign dout_I[i*ACC_LEN +: ACC_LEN] = dout_im_q;
        assign out_valid[i]                 = ov_q;
        assign part_vec[i]                  = part_q;
`ifdef CMAC_PE_ROW_SAT_EN
        assign sat_flag[i]                  = sf_q;
`else
        assign sat_flag[i]                  = 1'b0;
`endif
    end

    assign busy = (|chain_v) | (|part_vec);

endmodule

// File: tb/tb_cmac_pe_row.sv
// Self-checking bench for cmac_pe_row (NUM_PE=4, WORD_LEN=24, ACC_LEN=64, OUT_LEN=32).
module tb_cmac_pe_row;

    localparam int NP = 4;
    localparam int W  = 24;
    localparam int AL = 64;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -SMAX - 1;

    typedef struct packed {
        logic          v;
        logic          l;
        logic          c;
        logic [NP*W-1:0] dr;
        logic [NP*W-1:0] di;
        logic [W-1:0]  wr;
        logic [W-1:0]  wi;
    } term_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            clr = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_last = 1'b0;
    logic [NP*W-1:0] din_R = '0;
    logic [NP*W-1:0] din_I = '0;
    logic [W-1:0]    w_R = '0;
    logic [W-1:0]    w_I = '0;
    logic [NP*AL-1:0] dout_R;
    logic [NP*AL-1:0] dout_I;
    logic [NP-1:0]   out_valid;
    logic [NP-1:0]   sat_flag;
    logic            busy;

    cmac_pe_row #(
        .WORD_LEN(W),
        .NUM_PE  (NP),
        .ACC_LEN (AL),
        .OUT_LEN (32)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .in_valid (in_valid),
        .in_last  (in_last),
        .din_R    (din_R),
        .din_I    (din_I),
        .w_R      (w_R),
        .w_I      (w_I),
        .dout_R   (dout_R),
        .dout_I   (dout_I),
        .out_valid(out_valid),
        .sat_flag (sat_flag),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Reference model: hv/hl/hw/hd hold the term sampled k edges ago; stage k works on entry k.
    bit     hv [NP];
    bit     hl [NP];
    longint hwr [NP];
    longint hwi [NP];
    longint hdr [NP][NP];
    longint hdi [NP][NP];
    longint acc_r [NP];
    longint acc_i [NP];
    longint edr [NP];
    longint edi [NP];
    bit     eov [NP];
    bit     esf [NP];
    bit     part [NP];
    bit     ebusy;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic term_t mk_term(logic v, logic l, logic c, int wr, int wi);
        term_t t;
        t    = '0;
        t.v  = v;
        t.l  = l;
        t.c  = c;
        t.wr = W'(wr);
        t.wi = W'(wi);
        return t;
    endfunction

    function automatic term_t set_lane(term_t t_in, int i, int re, int im);
        term_t t;
        t = t_in;
        t.dr[i*W +: W] = W'(re);
        t.di[i*W +: W] = W'(im);
        return t;
    endfunction

    task automatic model_clear(bit with_dout);
        for (int k = 0; k < NP; k++) begin
            hv[k]  = 0;
            hl[k]  = 0;
            hwr[k] = 0;
            hwi[k] = 0;
            for (int j = 0; j < NP; j++) begin
                hdr[k][j] = 0;
                hdi[k][j] = 0;
            end
            acc_r[k] = 0;
            acc_i[k] = 0;
            eov[k]   = 0;
            esf[k]   = 0;
            part[k]  = 0;
            if (with_dout) begin
                edr[k] = 0;
                edi[k] = 0;
            end
        end
        ebusy = 0;
    endtask

    // Drive one cycle, advance the model at the edge, and return 1 time unit after it.
    task automatic step(input term_t t);
        longint pr, pi, sr, si;
        bit     sat;
        in_valid = t.v;
        in_last  = t.l;
        clr      = t.c;
        din_R    = t.dr;
        din_I    = t.di;
        w_R      = t.wr;
        w_I      = t.wi;
        @(posedge clk);
        if (t.c) begin
            model_clear(0);
        end else begin
            for (int k = NP - 1; k > 0; k--) begin
                hv[k]  = hv[k-1];
                hl[k]  = hl[k-1];
                hwr[k] = hwr[k-1];
                hwi[k] = hwi[k-1];
                for (int j = 0; j < NP; j++) begin
                    hdr[k][j] = hdr[k-1][j];
                    hdi[k][j] = hdi[k-1][j];
                end
            end
            hv[0]  = t.v;
            hl[0]  = t.v & t.l;
            hwr[0] = $signed(t.wr);
            hwi[0] = $signed(t.wi);
            for (int j = 0; j < NP; j++) begin
                hdr[0][j] = $signed(t.dr[j*W +: W]);
                hdi[0][j] = $signed(t.di[j*W +: W]);
            end
            for (int i = 0; i < NP; i++) begin
                eov[i] = 0;
                esf[i] = 0;
                if (hv[i]) begin
                    pr = hdr[i][i] * hwr[i] - hdi[i][i] * hwi[i];
                    pi = hdr[i][i] * hwi[i] + hdi[i][i] * hwr[i];
                    if (hl[i]) begin
                        sr  = acc_r[i] + pr;
                        si  = acc_i[i] + pi;
                        sat = 0;
`ifdef CMAC_PE_ROW_SAT_EN
                        if (sr > SMAX) begin sr = SMAX; sat = 1; end
                        else if (sr < SMIN) begin sr = SMIN; sat = 1; end
                        if (si > SMAX) begin si = SMAX; sat = 1; end
                        else if (si < SMIN) begin si = SMIN; sat = 1; end
`endif
                        edr[i]   = sr;
                        edi[i]   = si;
                        eov[i]   = 1;
                        esf[i]   = sat;
                        acc_r[i] = 0;
                        acc_i[i] = 0;
                        part[i]  = 0;
                    end else begin
                        acc_r[i] = acc_r[i] + pr;
                        acc_i[i] = acc_i[i] + pi;
                        part[i]  = 1;
                    end
                end
            end
        end
        ebusy = 0;
        for (int k = 0; k < NP - 1; k++) ebusy |= hv[k];
        for (int i = 0; i < NP; i++) ebusy |= part[i];
        #1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        model_clear(1);
        for (int i = 0; i < NP; i++) begin
            n_checks++;
            if (out_valid[i] !== 1'b0 || sat_flag[i] !== 1'b0 ||
                dout_R[i*AL +: AL] !== 64'd0 || dout_I[i*AL +: AL] !== 64'd0) begin
                n_fail++;
                $display("FAIL reset lane %0d: got ov=%b sf=%b R=%0d I=%0d, want all 0", i,
                         out_valid[i], sat_flag[i], dout_R[i*AL +: AL], dout_I[i*AL +: AL]);
            end
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset busy: got %b want 0", busy);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_term();
        term_t seq[$];
        term_t t;
        t = mk_term(1, 1, 0, 2, 3);
        for (int i = 0; i < NP; i++) t = set_lane(t, i, i + 1, 0);
        seq.push_back(t);
        repeat (6) seq.push_back(mk_term(0, 0, 0, 0, 0));
        foreach (seq[n]) begin
            step(seq[n]);
            for (int i = 0; i < NP; i++) begin
                n_checks++;
                if (out_valid[i] !== eov[i] || dout_R[i*AL +: AL] !== edr[i] ||
                    dout_I[i*AL +: AL] !== edi[i] || sat_flag[i] !== esf[i]) begin
                    n_fail++;
                    $display("FAIL single cyc%0d lane%0d: got ov=%b R=%0d I=%0d sf=%b, want ov=%b R=%0d I=%0d sf=%b",
                             n, i, out_valid[i], $signed(dout_R[i*AL +: AL]),
                             $signed(dout_I[i*AL +: AL]), sat_flag[i], eov[i], edr[i], edi[i], esf[i]);
                end
            end
            n_checks++;
            if (busy !== ebusy) begin
                n_fail++;
                $display("FAIL single cyc%0d busy: got %b want %b", n, busy, ebusy);
            end
        end
        for (int i = 0; i < NP; i++) begin
            n_checks++;
            if ($signed(dout_R[i*AL +: AL]) !== longint'(2 * (i + 1)) ||
                $signed(dout_I[i*AL +: AL]) !== longint'(3 * (i + 1))) begin
                n_fail++;
                $display("FAIL single final lane%0d: got (%0d,%0d) want (%0d,%0d)", i,
                         $signed(dout_R[i*AL +: AL]), $signed(dout_I[i*AL +: AL]),
                         2 * (i + 1), 3 * (i + 1));
            end
        end
    endtask

    task automatic test_bubble_sum();
        term_t seq[$];
        term_t t;
        int    pulse_cyc [NP];
        t = mk_term(1, 0, 0, 1, 1);
        for (int i = 0; i < NP; i++) t = set_lane(t, i, 1, 1);
        seq.push_back(t);
        seq.push_back(mk_term(0, 0, 0, 0, 0));
        t = mk_term(1, 0, 0, 1, 1);
        for (int i = 0; i < NP; i++) t = set_lane(t, i, 2, 0);
        seq.push_back(t);
        t = mk_term(1, 1, 0, 1, 1);
        for (int i = 0; i < NP; i++) t = set_lane(t, i, 0, -1);
        seq.push_back(t);
        repeat (6) seq.push_back(mk_term(0, 0, 0, 0, 0));
        for (int i = 0; i < NP; i++) pulse_cyc[i] = -1;
        foreach (seq[n]) begin
            step(seq[n]);
            for (int i = 0; i < NP; i++) begin
                if (out_valid[i] === 1'b1) pulse_cyc[i] = n;
                n_checks++;
                if (out_valid[i] !== eov[i] || dout_R[i*AL +: AL] !== edr[i] ||
                    dout_I[i*AL +: AL] !== edi[i] || sat_flag[i] !== esf[i]) begin
                    n_fail++;
                    $display("FAIL bubble cyc%0d lane%0d: got ov=%b R=%0d I=%0d, want ov=%b R=%0d I=%0d",
                             n, i, out_valid[i], $signed(dout_R[i*AL +: AL]),
                             $signed(dout_I[i*AL +: AL]), eov[i], edr[i], edi[i]);
                end
            end
            n_checks++;
            if (busy !== ebusy) begin
                n_fail++;
                $display("FAIL bubble cyc%0d busy: got %b want %b", n, busy, ebusy);
            end
        end
        for (int i = 0; i < NP; i++) begin
            n_checks++;
            if ($signed(dout_R[i*AL +: AL]) !== 64'sd3 || $signed(dout_I[i*AL +: AL]) !== 64'sd3 ||
                pulse_cyc[i] !== 3 + i) begin
                n_fail++;
                $display("FAIL bubble final lane%0d: got (%0d,%0d) at cyc %0d want (3,3) at cyc %0d",
                         i, $signed(dout_R[i*AL +: AL]), $signed(dout_I[i*AL +: AL]),
                         pulse_cyc[i], 3 + i);
            end
        end
    endtask

    task automatic test_back_to_back();
        term_t seq[$];
        term_t t;
        int    ov0_run;
        t = mk_term(1, 1, 0, 1, 0);
        for (int i = 0; i < NP; i++) t = set_lane(t, i, i + 1, 2);
        seq.push_back(t);
        t = mk_term(1, 1, 0, 2, -1);
        for (int i = 0; i < NP; i++) t = set_lane(t, i, -(i + 3), 1);
        seq.push_back(t);
        repeat (5) seq.push_back(mk_term(0, 0, 0, 0, 0));
        ov0_run = 0;
        foreach (seq[n]) begin
            step(seq[n]);
            if (n < 2 && out_valid[0] === 1'b1) ov0_run++;
            for (int i = 0; i < NP; i++) begin
                n_checks++;
                if (out_valid[i] !== eov[i] || dout_R[i*AL +: AL] !== edr[i] ||
                    dout_I[i*AL +: AL] !== edi[i] || sat_flag[i] !== esf[i]) begin
                    n_fail++;
                    $display("FAIL b2b cyc%0d lane%0d: got ov=%b R=%0d I=%0d, want ov=%b R=%0d I=%0d",
                             n, i, out_valid[i], $signed(dout_R[i*AL +: AL]),
                             $signed(dout_I[i*AL +: AL]), eov[i], edr[i], edi[i]);
                end
            end
            n_checks++;
            if (busy !== ebusy) begin
                n_fail++;
                $display("FAIL b2b cyc%0d busy: got %b want %b", n, busy, ebusy);
            end
        end
        n_checks++;
        if (ov0_run !== 2) begin
            n_fail++;
            $display("FAIL b2b out_valid[0] run: got %0d cycles want 2", ov0_run);
        end
        for (int i = 0; i < NP; i++) begin
            n_checks++;
            if ($signed(dout_R[i*AL +: AL]) !== longint'(-2 * i - 5) ||
                $signed(dout_I[i*AL +: AL]) !== longint'(i + 5)) begin
                n_fail++;
                $display("FAIL b2b final lane%0d: got (%0d,%0d) want (%0d,%0d)", i,
                         $signed(dout_R[i*AL +: AL]), $signed(dout_I[i*AL +: AL]), -2 * i - 5, i + 5);
            end
        end
    endtask

    task automatic test_clr();
        term_t   seq[$];
        term_t   t;
        int      ov_seen;
        logic [NP*AL-1:0] held_r;
        held_r = dout_R;
        for (int k = 0; k < 2; k++) begin
            t = mk_term(1, 0, 0, 3, -2);
            for (int i = 0; i < NP; i++) t = set_lane(t, i, 10 + k + i, -4 - i);
            seq.push_back(t);
        end
        t = mk_term(1, 1, 1, 3, -2);
        for (int i = 0; i < NP; i++) t = set_lane(t, i, 9, 9);
        seq.push_back(t);
        repeat (4) seq.push_back(mk_term(0, 0, 0, 0, 0));
        t = mk_term(1, 1, 0, 1, 0);
        for (int i = 0; i < NP; i++) t = set_lane(t, i, 5, 0);
        seq.push_back(t);
        repeat (5) seq.push_back(mk_term(0, 0, 0, 0, 0));
        ov_seen = 0;
        foreach (seq[n]) begin
            step(seq[n]);
            if (n < 7 && out_valid !== '0) ov_seen++;
            for (int i = 0; i < NP; i++) begin
                n_checks++;
                if (out_valid[i] !== eov[i] || dout_R[i*AL +: AL] !== edr[i] ||
                    dout_I[i*AL +: AL] !== edi[i] || sat_flag[i] !== esf[i]) begin
                    n_fail++;
                    $display("FAIL clr cyc%0d lane%0d: got ov=%b R=%0d I=%0d, want ov=%b R=%0d I=%0d",
                             n, i, out_valid[i], $signed(dout_R[i*AL +: AL]),
                             $signed(dout_I[i*AL +: AL]), eov[i], edr[i], edi[i]);
                end
            end
            n_checks++;
            if (busy !== ebusy) begin
                n_fail++;
                $display("FAIL clr cyc%0d busy: got %b want %b", n, busy, ebusy);
            end
            if (n == 6) begin
                n_checks++;
                if (dout_R !== held_r) begin
                    n_fail++;
                    $display("FAIL clr dout held: got %h want %h", dout_R, held_r);
                end
            end
        end
        n_checks++;
        if (ov_seen !== 0) begin
            n_fail++;
            $display("FAIL clr no pulse: got %0d pulsing cycles want 0", ov_seen);
        end
        for (int i = 0; i < NP; i++) begin
            n_checks++;
            if ($signed(dout_R[i*AL +: AL]) !== 64'sd5 || $signed(dout_I[i*AL +: AL]) !== 64'sd0) begin
                n_fail++;
                $display("FAIL clr final lane%0d: got (%0d,%0d) want (5,0)", i,
                         $signed(dout_R[i*AL +: AL]), $signed(dout_I[i*AL +: AL]));
            end
        end
    endtask

    task automatic test_saturation();
        term_t  seq[$];
        term_t  t;
        longint want_r;
        logic   want_sf;
        int     sf_seen [NP];
`ifdef CMAC_PE_ROW_SAT_EN
        want_r  = 64'sd2147483647;
        want_sf = 1'b1;
`else
        want_r  = 64'sd140737479966720;
        want_sf = 1'b0;
`endif
        t = mk_term(1, 1, 0, -8388608, 8388607);
        for (int i = 0; i < NP; i++) t = set_lane(t, i, -8388608, -8388608);
        seq.push_back(t);
        repeat (5) seq.push_back(mk_term(0, 0, 0, 0, 0));
        for (int i = 0; i < NP; i++) sf_seen[i] = 0;
        foreach (seq[n]) begin
            step(seq[n]);
            for (int i = 0; i < NP; i++) begin
                if (sat_flag[i] === 1'b1 && out_valid[i] === 1'b1) sf_seen[i]++;
                n_checks++;
                if (out_valid[i] !== eov[i] || dout_R[i*AL +: AL] !== edr[i] ||
                    dout_I[i*AL +: AL] !== edi[i] || sat_flag[i] !== esf[i]) begin
                    n_fail++;
                    $display("FAIL sat cyc%0d lane%0d: got ov=%b R=%0d I=%0d sf=%b, want ov=%b R=%0d I=%0d sf=%b",
                             n, i, out_valid[i], $signed(dout_R[i*AL +: AL]),
                             $signed(dout_I[i*AL +: AL]), sat_flag[i], eov[i], edr[i], edi[i], esf[i]);
                end
            end
        end
        for (int i = 0; i < NP; i++) begin
            n_checks++;
            if ($signed(dout_R[i*AL +: AL]) !== want_r || $signed(dout_I[i*AL +: AL]) !== 64'sd8388608 ||
                sf_seen[i] !== int'(want_sf)) begin
                n_fail++;
                $display("FAIL sat final lane%0d: got (%0d,%0d) flag pulses %0d want (%0d,8388608) pulses %0d",
                         i, $signed(dout_R[i*AL +: AL]), $signed(dout_I[i*AL +: AL]), sf_seen[i],
                         want_r, want_sf);
            end
        end
    endtask

    task automatic test_reset_mid_op();
        term_t seq[$];
        term_t t;
        t = mk_term(1, 0, 0, 3, -2);
        for (int i = 0; i < NP; i++) t = set_lane(t, i, 20 + i, 7);
        step(t);
        in_valid = 1'b1;
        in_last  = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        model_clear(1);
        for (int i = 0; i < NP; i++) begin
            n_checks++;
            if (out_valid[i] !== 1'b0 || sat_flag[i] !== 1'b0 ||
                dout_R[i*AL +: AL] !== 64'd0 || dout_I[i*AL +: AL] !== 64'd0) begin
                n_fail++;
                $display("FAIL midrst lane %0d: got ov=%b R=%0d I=%0d want all 0", i,
                         out_valid[i], $signed(dout_R[i*AL +: AL]), $signed(dout_I[i*AL +: AL]));
            end
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst busy: got %b want 0", busy);
        end
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        t = mk_term(1, 1, 0, 4, 5);
        for (int i = 0; i < NP; i++) t = set_lane(t, i, 7 + i, -3);
        seq.push_back(t);
        repeat (5) seq.push_back(mk_term(0, 0, 0, 0, 0));
        foreach (seq[n]) begin
            step(seq[n]);
            for (int i = 0; i < NP; i++) begin
                n_checks++;
                if (out_valid[i] !== eov[i] || dout_R[i*AL +: AL] !== edr[i] ||
                    dout_I[i*AL +: AL] !== edi[i] || sat_flag[i] !== esf[i]) begin
                    n_fail++;
                    $display("FAIL midrst cyc%0d lane%0d: got ov=%b R=%0d I=%0d, want ov=%b R=%0d I=%0d",
                             n, i, out_valid[i], $signed(dout_R[i*AL +: AL]),
                             $signed(dout_I[i*AL +: AL]), eov[i], edr[i], edi[i]);
                end
            end
            n_checks++;
            if (busy !== ebusy) begin
                n_fail++;
                $display("FAIL midrst cyc%0d busy: got %b want %b", n, busy, ebusy);
            end
        end
        for (int i = 0; i < NP; i++) begin
            n_checks++;
            if ($signed(dout_R[i*AL +: AL]) !== longint'(43 + 4 * i) ||
                $signed(dout_I[i*AL +: AL]) !== longint'(23 + 5 * i)) begin
                n_fail++;
                $display("FAIL midrst final lane%0d: got (%0d,%0d) want (%0d,%0d)", i,
                         $signed(dout_R[i*AL +: AL]), $signed(dout_I[i*AL +: AL]),
                         43 + 4 * i, 23 + 5 * i);
            end
        end
    endtask

    task automatic test_random();
        term_t t;
        logic  v, l, c;
        for (int n = 0; n < 300; n++) begin
            v = ($urandom_range(3) != 0);
            l = v && ($urandom_range(2) == 0);
            c = ($urandom_range(24) == 0);
            if ($urandom_range(1) == 0)
                t = mk_term(v, l, c, $urandom_range(200) - 100, $urandom_range(200) - 100);
            else
                t = mk_term(v, l, c, int'($urandom), int'($urandom));
            for (int i = 0; i < NP; i++)
                t = set_lane(t, i, int'($urandom), int'($urandom));
            step(t);
            for (int i = 0; i < NP; i++) begin
                n_checks++;
                if (out_valid[i] !== eov[i] || dout_R[i*AL +: AL] !== edr[i] ||
                    dout_I[i*AL +: AL] !== edi[i] || sat_flag[i] !== esf[i]) begin
                    n_fail++;
                    $display("FAIL random cyc%0d lane%0d: got ov=%b R=%0d I=%0d sf=%b, want ov=%b R=%0d I=%0d sf=%b",
                             n, i, out_valid[i], $signed(dout_R[i*AL +: AL]),
                             $signed(dout_I[i*AL +: AL]), sat_flag[i], eov[i], edr[i], edi[i], esf[i]);
                end
            end
            n_checks++;
            if (busy !== ebusy) begin
                n_fail++;
                $display("FAIL random cyc%0d busy: got %b want %b", n, busy, ebusy);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear(1);
        test_reset();
        test_single_term();
        test_bubble_sum();
        test_back_to_back();
        test_clr();
        test_saturation();
        test_reset_mid_op();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
